// File: rtl/mpadder_iter_pkg.sv
// mpadder_iter_pkg: shared FSM state encoding for the iterative multi-precision adder.
package mpadder_iter_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/mp_word_adder.sv
// mp_word_adder: combinational single-limb adder with carry in/out.
module mp_word_adder #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] a_i,
  input  logic [WORD-1:0] b_i,
  input  logic            cin_i,
  output logic [WORD-1:0] sum_o,
  output logic            cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD{1'b0}}, cin_i};
endmodule

// File: rtl/mpadder_iter.sv
// mpadder_iter: iterative WIDTH-bit add/sub, one WORD-bit limb per cycle, LSB limb first.
module mpadder_iter
  import mpadder_iter_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int WORD  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             busy,
  output logic             done
);
  localparam int NWORDS = WIDTH / WORD;
  localparam int CW     = $clog2(NWORDS);
  if (NWORDS < 2 || WIDTH % WORD != 0) begin : g_bad_params
    $error("mpadder_iter: WIDTH must be a multiple of WORD with at least two limbs");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, done_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WORD-1:0]  sum;
  logic             cout;
  mp_word_adder #(.WORD(WORD)) u_add (
    .a_i   (a_q[WORD-1:0]),
    .b_i   (b_q[WORD-1:0]),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(cout)
  );
  // Subtraction is A + ~B + 1: the inverted B and the preset carry do the work.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && start) begin
      a_d     = A;
      b_d     = subtract ? ~B : B;
      carry_d = subtract;
      cnt_d   = CW'(NWORDS - 1);
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      res_d   = {sum, res_q[WIDTH-1:WORD]};
      a_d     = a_q >> WORD;
      b_d     = b_q >> WORD;
      carry_d = cout;
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == '0) ? S_FIN : S_RUN;
    end else if (state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_FIN);
    end
  end
  assign C    = {carry_q, res_q};
  assign busy = (state_q == S_RUN);
  assign done = done_q;
endmodule

// File: tb/tb_mpadder_iter.sv
// tb_mpadder_iter: three adder configurations checked against a plain-arithmetic reference.
module tb_mpadder_iter;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          subtract = 1'b0;
  logic [2:0]    start_v = 3'b000;
  logic [1023:0] A = '0;
  logic [1023:0] B = '0;
  logic [128:0]  c0;
  logic [256:0]  c1;
  logic [1024:0] c2;
  logic [2:0]    busy_v, done_v;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  mpadder_iter #(.WIDTH(128), .WORD(64)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .subtract(subtract),
    .A(A[127:0]), .B(B[127:0]), .C(c0), .busy(busy_v[0]), .done(done_v[0])
  );
  mpadder_iter #(.WIDTH(256), .WORD(32)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .subtract(subtract),
    .A(A[255:0]), .B(B[255:0]), .C(c1), .busy(busy_v[1]), .done(done_v[1])
  );
  mpadder_iter #(.WIDTH(1024), .WORD(64)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .subtract(subtract),
    .A(A), .B(B), .C(c2), .busy(busy_v[2]), .done(done_v[2])
  );

  function automatic int w_of(input int s);
    return s == 0 ? 128 : s == 1 ? 256 : 1024;
  endfunction

  function automatic int word_of(input int s);
    return s == 1 ? 32 : 64;
  endfunction

  function automatic logic [1024:0] c_of(input int s);
    return s == 0 ? 1025'(c0) : s == 1 ? 1025'(c1) : c2;
  endfunction

  function automatic logic [1023:0] rnd();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: exact sum, or difference modulo 2^w with a no-borrow flag on top.
  function automatic logic [1024:0] model(input int w, input logic [1023:0] a, input logic [1023:0] b,
                                          input logic sub);
    logic [1024:0] mask, am, bm, r;
    mask = (1025'(1) << w) - 1025'(1);
    am = {1'b0, a} & mask;
    bm = {1'b0, b} & mask;
    if (!sub) return am + bm;
    r = (am - bm) & mask;
    if (am >= bm) r[w] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [1024:0] got, input logic [1024:0] exp);
    logic [1024:0] d;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      d = got ^ exp;
      if (|d[1024:512])
        $display("FAIL %s got[1024:512]=%h exp[1024:512]=%h", tag, got[1024:512], exp[1024:512]);
      else
        $display("FAIL %s got[511:0]=%h exp[511:0]=%h", tag, got[511:0], exp[511:0]);
    end
  endtask

  task automatic run_op(input int s, input logic [1023:0] a, input logic [1023:0] b, input logic sub);
    logic [1024:0] exp;
    int nw, n, nb;
    nw  = w_of(s) / word_of(s);
    exp = model(w_of(s), a, b, sub);
    @(negedge clk);
    A = a;
    B = b;
    subtract = sub;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    A = rnd();
    B = rnd();
    subtract = 1'($urandom);
    n  = 1;
    nb = 0;
    while (!done_v[s] && n < 40) begin
      nb += int'(busy_v[s]);
      @(negedge clk);
      n++;
    end
    check("latency", 1025'(n), 1025'(nw + 1));
    check("busy_cycles", 1025'(nb), 1025'(nw));
    check("busy_at_fin", 1025'(busy_v[s]), '0);
    check("result", c_of(s), exp);
    @(negedge clk);
    check("done_pulse", 1025'(done_v[s]), '0);
    check("result_hold", c_of(s), exp);
  endtask

  initial begin
    logic [1023:0] a1, b1, a2, b2, ra, rb;
    int s, m;
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_c", c_of(i), '0);
      check("rst_busy", 1025'(busy_v[i]), '0);
      check("rst_done", 1025'(done_v[i]), '0);
    end
    @(negedge clk);
    rst = 1'b1;

    run_op(0, {896'b0, {128{1'b1}}}, 1024'd1, 1'b0);
    run_op(0, 1024'd5, 1024'd7, 1'b1);
    run_op(0, 1024'd7, 1024'd5, 1'b1);
    run_op(0, 1024'd0, 1024'd0, 1'b1);
    run_op(0, {960'b0, {64{1'b1}}}, 1024'd1, 1'b0);

    // start held high throughout with operands changing every cycle
    a1 = rnd(); b1 = rnd(); a2 = rnd(); b2 = rnd();
    @(negedge clk);
    A = a1; B = b1; subtract = 1'b0; start_v[0] = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin A = a2; B = b2; end
      else begin A = rnd(); B = rnd(); end
      check("b2b_done", 1025'(done_v[0]), 1025'(cyc == 3 || cyc == 7));
      check("b2b_busy", 1025'(busy_v[0]), 1025'(cyc inside {1, 2, 5, 6}));
      if (cyc == 3) check("b2b_res1", 1025'(c0), model(128, a1, b1, 1'b0));
      if (cyc == 7) check("b2b_res2", 1025'(c0), model(128, a2, b2, 1'b0));
    end
    start_v[0] = 1'b0;

    // asynchronous reset in the middle of a subtraction
    @(negedge clk);
    A = rnd(); B = rnd(); subtract = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_c", 1025'(c0), '0);
    check("arst_busy", 1025'(busy_v[0]), '0);
    check("arst_done", 1025'(done_v[0]), '0);
    @(negedge clk);
    rst = 1'b1;
    ra = rnd(); rb = rnd();
    run_op(0, ra, rb, 1'b1);
    ra = rnd(); rb = rnd();
    run_op(0, ra, rb, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      s  = (i % 2) + 1;
      ra = rnd();
      rb = rnd();
      m  = int'($urandom_range(0, 3));
      if (m == 1) rb = ra;
      if (m == 2) ra = '1;
      if (m == 3) rb = ~ra;
      run_op(s, ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
